// File: rtl/CPU_Defines.sv
// Shared pipeline definitions: hazard control bundle and divide sequencer states.
package CPU_Defines;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } DivStateType;

    typedef struct packed {
        logic PCWr;
        logic IF_IDWr;
        logic ID_Flush;
        logic EXE_Flush;
        logic MEM_Flush;
        logic EXE_Stall;
    } HazardCtrlType;

    // Wide enough for the largest legal divide latency (63).
    localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/div_seq_fsm.sv
// Divide sequencer: issues start/abort pulses, counts the divide latency and
// flags the single cycle in which the divide result may be written to HILO.
module div_seq_fsm
    import CPU_Defines::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic div_req,
    input  logic except_valid,
    output logic busy,
    output logic start,
    output logic abort,
    output logic done
);

    localparam logic [DIV_CNT_W-1:0] LOAD_VAL = DIV_CNT_W'(DIV_CYCLES - 1);
    localparam logic [DIV_CNT_W-1:0] ONE      = DIV_CNT_W'(1);

    DivStateType          state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    // The start cycle already stalls, so DIV_WAIT ends when the decremented
    // count reaches zero; this makes the whole stall exactly DIV_CYCLES long.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        case (state_q)
            RUN: begin
                if (div_req && !except_valid) begin
                    start   = 1'b1;
                    busy    = 1'b1;
                    cnt_d   = LOAD_VAL;
                    state_d = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (except_valid) begin
                    abort   = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    busy = 1'b1;
                    if (cnt_q <= ONE) begin
                        cnt_d   = '0;
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            DIV_DONE: begin
                done    = !except_valid;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: exception flush, divide
// stall and load-use bubble in fixed priority, plus a saturating stall counter.
module pipeline_hazard_ctrl
    import CPU_Defines::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             EXE_ReadMem,
    input  logic [4:0]       EXE_Dst,
    input  logic             EXE_DivReq,
    input  logic             MEM_ExceptValid,
    output logic             IF_PCWr,
    output logic             IF_IDWr,
    output logic             ID_Flush,
    output logic             EXE_Flush,
    output logic             MEM_Flush,
    output logic             EXE_Stall,
    output logic             Div_Start,
    output logic             Div_Abort,
    output logic             Div_Done,
    output logic [CNT_W-1:0] Stall_Cnt
);

    logic          lu;
    logic          div_busy, div_start, div_abort, div_done;
    HazardCtrlType ctrl;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign lu = EXE_ReadMem && (EXE_Dst != 5'd0) &&
                ((ID_UsesRs && (ID_rs == EXE_Dst)) ||
                 (ID_UsesRt && (ID_rt == EXE_Dst)));

    div_seq_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk          (clk),
        .rst          (rst),
        .div_req      (EXE_DivReq),
        .except_valid (MEM_ExceptValid),
        .busy         (div_busy),
        .start        (div_start),
        .abort        (div_abort),
        .done         (div_done)
    );

    // Reset holds every stage flushed with the PC frozen.
    always_comb begin
        ctrl         = '0;
        ctrl.PCWr    = 1'b1;
        ctrl.IF_IDWr = 1'b1;
        if (!rst) begin
            ctrl.PCWr      = 1'b0;
            ctrl.IF_IDWr   = 1'b0;
            ctrl.ID_Flush  = 1'b1;
            ctrl.EXE_Flush = 1'b1;
            ctrl.MEM_Flush = 1'b1;
        end else if (MEM_ExceptValid) begin
            ctrl.ID_Flush  = 1'b1;
            ctrl.EXE_Flush = 1'b1;
            ctrl.MEM_Flush = 1'b1;
        end else if (div_busy) begin
            ctrl.PCWr      = 1'b0;
            ctrl.IF_IDWr   = 1'b0;
            ctrl.EXE_Stall = 1'b1;
            ctrl.MEM_Flush = 1'b1;
        end else if (lu) begin
            ctrl.PCWr      = 1'b0;
            ctrl.IF_IDWr   = 1'b0;
            ctrl.EXE_Flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.PCWr && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IF_PCWr   = ctrl.PCWr;
    assign IF_IDWr   = ctrl.IF_IDWr;
    assign ID_Flush  = ctrl.ID_Flush;
    assign EXE_Flush = ctrl.EXE_Flush;
    assign MEM_Flush = ctrl.MEM_Flush;
    assign EXE_Stall = ctrl.EXE_Stall;
    assign Div_Start = rst && div_start;
    assign Div_Abort = rst && div_abort;
    assign Div_Done  = rst && div_done;
    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus divide/exception
// sequences, with a CNT_W=4 copy sharing the stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rdm;
        logic [4:0] dst;
        logic       dreq;
        logic       exc;
        logic [8:0] exp;
    } vec_t;

    // Expected bits: {PCWr, IDWr, ID_Flush, EXE_Flush, MEM_Flush, EXE_Stall, Start, Abort, Done}
    localparam logic [8:0] NORM    = 9'b110000000;
    localparam logic [8:0] LU      = 9'b000100000;
    localparam logic [8:0] EXC     = 9'b111110000;
    localparam logic [8:0] DSTL    = 9'b000011000;
    localparam logic [8:0] DSTART  = 9'b000011100;
    localparam logic [8:0] ABORT   = 9'b111110010;
    localparam logic [8:0] DONE    = 9'b110000001;
    localparam logic [8:0] DONE_LU = 9'b000100001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ID_rs = '0, ID_rt = '0, EXE_Dst = '0;
    logic        ID_UsesRs = 1'b0, ID_UsesRt = 1'b0, EXE_ReadMem = 1'b0;
    logic        EXE_DivReq = 1'b0, MEM_ExceptValid = 1'b0;
    logic        IF_PCWr, IF_IDWr, ID_Flush, EXE_Flush, MEM_Flush, EXE_Stall;
    logic        Div_Start, Div_Abort, Div_Done;
    logic [31:0] Stall_Cnt;
    logic        s_pcwr, s_idwr, s_idf, s_exf, s_memf, s_stall, s_start, s_abort, s_done;
    logic [3:0]  s_cnt;

    int checks = 0;
    int failures = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EXE_ReadMem(EXE_ReadMem),
        .EXE_Dst(EXE_Dst), .EXE_DivReq(EXE_DivReq), .MEM_ExceptValid(MEM_ExceptValid),
        .IF_PCWr(IF_PCWr), .IF_IDWr(IF_IDWr), .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush),
        .MEM_Flush(MEM_Flush), .EXE_Stall(EXE_Stall), .Div_Start(Div_Start),
        .Div_Abort(Div_Abort), .Div_Done(Div_Done), .Stall_Cnt(Stall_Cnt)
    );

    pipeline_hazard_ctrl #(.DIV_CYCLES(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .EXE_ReadMem(EXE_ReadMem),
        .EXE_Dst(EXE_Dst), .EXE_DivReq(EXE_DivReq), .MEM_ExceptValid(MEM_ExceptValid),
        .IF_PCWr(s_pcwr), .IF_IDWr(s_idwr), .ID_Flush(s_idf), .EXE_Flush(s_exf),
        .MEM_Flush(s_memf), .EXE_Stall(s_stall), .Div_Start(s_start),
        .Div_Abort(s_abort), .Div_Done(s_done), .Stall_Cnt(s_cnt)
    );

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic rdm,
                                input logic [4:0] dst, input logic dreq, input logic exc,
                                input logic [8:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rdm = rdm;
        v.dst = dst; v.dreq = dreq; v.exc = exc; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] ctl_now();
        return {IF_PCWr, IF_IDWr, ID_Flush, EXE_Flush, MEM_Flush, EXE_Stall,
                Div_Start, Div_Abort, Div_Done};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drives one cycle of inputs, checks combinational controls and both counters.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int exp_sat;
        ID_rs = v.rs; ID_rt = v.rt; ID_UsesRs = v.urs; ID_UsesRt = v.urt;
        EXE_ReadMem = v.rdm; EXE_Dst = v.dst; EXE_DivReq = v.dreq; MEM_ExceptValid = v.exc;
        #4;
        exp_sat = (exp_stalls > 15) ? 15 : exp_stalls;
        check_output({tag, " ctl"}, {23'd0, ctl_now()}, {23'd0, v.exp});
        check_output({tag, " cnt"}, Stall_Cnt, exp_stalls);
        check_output({tag, " satcnt"}, {28'd0, s_cnt}, exp_sat);
        if (v.exp[8] == 1'b0) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    vec_t table_v[9];
    vec_t idle;

    initial begin
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NORM);
        table_v[0] = idle;
        table_v[1] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, LU);
        table_v[2] = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, NORM);
        table_v[3] = mk(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, LU);
        table_v[4] = mk(5'd9, 5'd3, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, NORM);
        table_v[5] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, NORM);
        table_v[6] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, EXC);
        table_v[7] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, EXC);
        table_v[8] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, EXC);

        // Reset state
        #2;
        check_output("reset ctl", {23'd0, ctl_now()}, {23'd0, 9'b001110000});
        check_output("reset cnt", Stall_Cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(table_v[i], $sformatf("vec%0d", i));
        end

        // Full divide with the request held through DIV_DONE
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DSTART), "div start");
        for (int i = 1; i < 32; i++) begin
            apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DSTL),
                           $sformatf("div wait%0d", i));
        end
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DONE), "div done");
        apply_stimulus(idle, "after div");

        // Divide overlapping a load-use: divide wins, load-use shows in DIV_DONE
        apply_stimulus(mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, DSTART), "divlu start");
        for (int i = 1; i < 32; i++) begin
            apply_stimulus(mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, DSTL),
                           $sformatf("divlu wait%0d", i));
        end
        apply_stimulus(mk(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, DONE_LU), "divlu done");
        apply_stimulus(idle, "after divlu");

        // Exception in stall cycle 10 aborts the divide
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DSTART), "abort start");
        for (int i = 1; i < 10; i++) begin
            apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DSTL),
                           $sformatf("abort wait%0d", i));
        end
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, ABORT), "abort");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(idle, $sformatf("post abort%0d", i));
        end
        // Back in RUN: a fresh request starts at once, then a late exception aborts it
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, DSTART), "restart");
        apply_stimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, ABORT), "abort2");
        apply_stimulus(idle, "final idle");

        check_output("sat final", {28'd0, s_cnt}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
